// File: rtl/sm_cpu_mc_pkg.sv
// Shared encodings for the multi-cycle schoolMIPS core: opcodes, functs, ALU ops,
// FSM states, instruction classes and bus handshake levels.
package sm_cpu_mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUBU = 6'b100011;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_SLTU = 6'b101011;
  localparam logic [5:0] F_SRL  = 6'b000010;

  localparam logic BUS_IDLE  = 1'b0;
  localparam logic BUS_REQ   = 1'b1;
  localparam logic BUS_READ  = 1'b0;
  localparam logic BUS_WRITE = 1'b1;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_OR   = 3'd2,
    ALU_SLTU = 3'd3,
    ALU_SRL  = 3'd4,
    ALU_LUI  = 3'd5
  } alu_op_e;

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    C_NOP    = 3'd0,
    C_ALU_R  = 3'd1,
    C_ALU_I  = 3'd2,
    C_LOAD   = 3'd3,
    C_STORE  = 3'd4,
    C_BRANCH = 3'd5
  } insn_class_e;

  // Anything not explicitly recognised falls into C_NOP.
  function automatic insn_class_e decode_class(input logic [31:0] ir);
    insn_class_e cls;
    cls = C_NOP;
    case (ir[31:26])
      OP_RTYPE: begin
        case (ir[5:0])
          F_ADDU, F_SUBU, F_OR, F_SLTU, F_SRL: cls = C_ALU_R;
          default:                             cls = C_NOP;
        endcase
      end
      OP_ADDIU, OP_LUI: cls = C_ALU_I;
      OP_LW:            cls = C_LOAD;
      OP_SW:            cls = C_STORE;
      OP_BEQ, OP_BNE:   cls = C_BRANCH;
      default:          cls = C_NOP;
    endcase
    return cls;
  endfunction

  function automatic alu_op_e decode_alu_op(input logic [31:0] ir);
    alu_op_e op;
    op = ALU_ADD;
    case (ir[31:26])
      OP_RTYPE: begin
        case (ir[5:0])
          F_SUBU:  op = ALU_SUB;
          F_OR:    op = ALU_OR;
          F_SLTU:  op = ALU_SLTU;
          F_SRL:   op = ALU_SRL;
          default: op = ALU_ADD;
        endcase
      end
      OP_LUI:         op = ALU_LUI;
      OP_BEQ, OP_BNE: op = ALU_SUB;
      default:        op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/sm_mc_alu.sv
// Combinational ALU for sm_cpu_mc; zero flag drives the beq/bne decision.
module sm_mc_alu
  import sm_cpu_mc_pkg::*;
(
  input  logic [31:0] srcA,
  input  logic [31:0] srcB,
  input  alu_op_e     oper,
  input  logic [4:0]  shamt,
  output logic [31:0] result,
  output logic        zero
);

  // Operation select; lui takes its immediate from the low half of srcB.
  always_comb begin
    result = 32'd0;
    case (oper)
      ALU_ADD:  result = srcA + srcB;
      ALU_SUB:  result = srcA - srcB;
      ALU_OR:   result = srcA | srcB;
      ALU_SLTU: result = (srcA < srcB) ? 32'd1 : 32'd0;
      ALU_SRL:  result = srcB >> shamt;
      ALU_LUI:  result = {srcB[15:0], 16'd0};
      default:  result = 32'd0;
    endcase
    zero = (result == 32'd0);
  end

endmodule

// File: rtl/sm_cpu_mc.sv
// Multi-cycle schoolMIPS core with req/ack instruction and data buses.
// Optional debug register read port enabled by defining SM_CPU_MC_DEBUG_EN.
module sm_cpu_mc
  import sm_cpu_mc_pkg::*;
#(
  parameter int          IADDR_W  = 14,
  parameter int          DADDR_W  = 14,
  parameter int unsigned RESET_PC = 0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [IADDR_W-1:0] imem_addr,
  input  logic               imem_ack,
  input  logic [31:0]        imem_rdata,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [DADDR_W-1:0] dmem_addr,
  output logic [31:0]        dmem_wdata,
  input  logic               dmem_ack,
  input  logic [31:0]        dmem_rdata,
  output logic               retire
`ifdef SM_CPU_MC_DEBUG_EN
  ,
  input  logic [4:0]         regAddr,
  output logic [31:0]        regData
`endif
);

  state_e             state_q, state_d;
  logic [IADDR_W-1:0] pc_q, pc_d;
  logic [31:0]        ir_q, ir_d;
  logic [31:0]        a_q, a_d;
  logic [31:0]        b_q, b_d;
  logic [31:0]        alu_q, alu_d;
  logic [31:0]        mdr_q, mdr_d;
  logic [31:0]        rf_q [32];

  logic [4:0]         rs_s, rt_s, rd_s, wb_addr_s;
  logic [31:0]        imm_sext_s, rs_data_s, rt_data_s, src_b_s, wb_data_s;
  logic [31:0]        alu_result_s;
  logic               alu_zero_s, br_taken_s, rf_we_s;
  logic [IADDR_W-1:0] pc_inc_s, br_target_s;
  insn_class_e        cls_s;
  alu_op_e            alu_op_s;

  assign rs_s       = ir_q[25:21];
  assign rt_s       = ir_q[20:16];
  assign rd_s       = ir_q[15:11];
  assign imm_sext_s = {{16{ir_q[15]}}, ir_q[15:0]};
  assign cls_s      = decode_class(ir_q);
  assign alu_op_s   = decode_alu_op(ir_q);

  assign rs_data_s = (rs_s == 5'd0) ? 32'd0 : rf_q[rs_s];
  assign rt_data_s = (rt_s == 5'd0) ? 32'd0 : rf_q[rt_s];

  // Register-register ops and branch compares use B; everything else uses the immediate.
  assign src_b_s = ((cls_s == C_ALU_R) || (cls_s == C_BRANCH)) ? b_q : imm_sext_s;

  sm_mc_alu u_alu (
    .srcA   (a_q),
    .srcB   (src_b_s),
    .oper   (alu_op_s),
    .shamt  (ir_q[10:6]),
    .result (alu_result_s),
    .zero   (alu_zero_s)
  );

  assign pc_inc_s    = pc_q + IADDR_W'(1'b1);
  assign br_target_s = pc_inc_s + imm_sext_s[IADDR_W-1:0];
  assign br_taken_s  = (ir_q[31:26] == OP_BEQ) ? alu_zero_s : !alu_zero_s;

  assign wb_addr_s = (cls_s == C_ALU_R) ? rd_s : rt_s;
  assign wb_data_s = (cls_s == C_LOAD) ? mdr_q : alu_q;

  // Next-state, datapath register updates and bus/retire outputs.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    a_d        = a_q;
    b_d        = b_q;
    alu_d      = alu_q;
    mdr_d      = mdr_q;
    rf_we_s    = 1'b0;
    imem_req   = BUS_IDLE;
    imem_addr  = '0;
    dmem_req   = BUS_IDLE;
    dmem_we    = BUS_READ;
    dmem_addr  = '0;
    dmem_wdata = 32'd0;
    retire     = 1'b0;
    case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: begin
        imem_req  = BUS_REQ;
        imem_addr = pc_q;
        if (imem_ack) begin
          ir_d    = imem_rdata;
          state_d = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        a_d     = rs_data_s;
        b_d     = rt_data_s;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        case (cls_s)
          C_ALU_R, C_ALU_I: begin
            alu_d   = alu_result_s;
            state_d = S_WB;
          end
          C_LOAD, C_STORE: begin
            alu_d   = alu_result_s;
            state_d = S_MEM;
          end
          C_BRANCH: begin
            pc_d    = br_taken_s ? br_target_s : pc_inc_s;
            retire  = 1'b1;
            state_d = S_FETCH;
          end
          default: begin
            pc_d    = pc_inc_s;
            retire  = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEM: begin
        dmem_req  = BUS_REQ;
        dmem_addr = alu_q[DADDR_W-1:0];
        if (cls_s == C_STORE) begin
          dmem_we    = BUS_WRITE;
          dmem_wdata = b_q;
        end else begin
          dmem_we    = BUS_READ;
          dmem_wdata = 32'd0;
        end
        if (dmem_ack && (cls_s == C_STORE)) begin
          pc_d    = pc_inc_s;
          retire  = 1'b1;
          state_d = S_FETCH;
        end else if (dmem_ack) begin
          mdr_d   = dmem_rdata;
          state_d = S_WB;
        end else begin
          state_d = S_MEM;
        end
      end
      S_WB: begin
        rf_we_s = (wb_addr_s != 5'd0);
        pc_d    = pc_inc_s;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_RESET;
    endcase
  end

  // State and datapath registers; reset abandons any in-flight bus access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_RESET;
      pc_q    <= IADDR_W'(RESET_PC);
      ir_q    <= 32'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      alu_q   <= 32'd0;
      mdr_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      alu_q   <= alu_d;
      mdr_q   <= mdr_d;
    end
  end

  // Register file is deliberately left unreset; $0 is never written.
  always_ff @(posedge clk) begin
    if (rf_we_s) begin
      rf_q[wb_addr_s] <= wb_data_s;
    end
  end

`ifdef SM_CPU_MC_DEBUG_EN
  assign regData = (regAddr == 5'd0) ? 32'(pc_q) : rf_q[regAddr];
`endif

endmodule
